// File: rtl/spawn_sched.sv
// Spawn scheduler: counts frame ticks between spawns, draws a legal non-repeating lane
// from the RNG word and presents it on a valid/ready handshake with a ramping interval.
module spawn_sched #(
   parameter int NUM_LANES     = 20,
   parameter int INTERVAL_INIT = 30,
   parameter int MIN_INTERVAL  = 8,
   parameter int STEP          = 1,
   parameter int MAX_RETRY     = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic       frame_tick,
   input  logic [4:0] rng_data,
   input  logic       spawn_ready,
   output logic       spawn_valid,
   output logic [4:0] spawn_lane,
   output logic [7:0] spawn_count,
   output logic [7:0] cur_interval
);

   localparam logic [5:0] LANES_C    = 6'(NUM_LANES);
   localparam logic [7:0] INIT_C     = 8'(INTERVAL_INIT);
   localparam logic [7:0] MIN_C      = 8'(MIN_INTERVAL);
   localparam logic [7:0] STEP_C     = 8'(STEP);
   localparam logic [8:0] FLOOR_C    = 9'(MIN_INTERVAL + STEP);
   localparam logic [7:0] LAST_TRY_C = 8'(MAX_RETRY - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_DRAW  = 2'd2,
      ST_ISSUE = 2'd3
   } state_t;

   state_t     state_r, state_s;
   logic [7:0] timer_r, timer_s;
   logic [7:0] retry_r, retry_s;
   logic       has_last_r, has_last_s;
   logic [4:0] last_lane_r, last_lane_s;
   logic       valid_r, valid_s;
   logic [4:0] lane_r, lane_s;
   logic [7:0] count_r, count_s;
   logic [7:0] interval_r, interval_s;
   logic       draw_legal_s;
   logic       handshake_s;
   logic [7:0] ramped_s;

   // Lane used when every retry failed: step past the previous lane so it never repeats.
   function automatic logic [4:0] fallback_lane(input logic has_last, input logic [4:0] last);
      logic [5:0] inc;
      inc = {1'b0, last} + 6'd1;
      if (!has_last) begin
         fallback_lane = 5'd0;
      end else if (inc >= LANES_C) begin
         fallback_lane = 5'd0;
      end else begin
         fallback_lane = inc[4:0];
      end
   endfunction

   // Compare before subtracting so the interval can never wrap below the floor.
   function automatic logic [7:0] ramp_down(input logic [7:0] cur);
      if ({1'b0, cur} >= FLOOR_C) begin
         ramp_down = cur - STEP_C;
      end else begin
         ramp_down = MIN_C;
      end
   endfunction

   assign draw_legal_s = ({1'b0, rng_data} < LANES_C) &&
                         !(has_last_r && (rng_data == last_lane_r));
   assign handshake_s  = valid_r & spawn_ready;
   assign ramped_s     = ramp_down(interval_r);

   // Next-state and next-register logic for the scheduler FSM.
   always_comb begin
      state_s     = state_r;
      timer_s     = timer_r;
      retry_s     = retry_r;
      has_last_s  = has_last_r;
      last_lane_s = last_lane_r;
      lane_s      = lane_r;
      count_s     = count_r;
      interval_s  = interval_r;
      case (state_r)
         ST_IDLE: begin
            if (enable) begin
               state_s = ST_WAIT;
               timer_s = interval_r;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (!enable) begin
               state_s = ST_IDLE;
            end else if (frame_tick) begin
               if (timer_r > 8'd1) begin
                  timer_s = timer_r - 8'd1;
               end else begin
                  state_s = ST_DRAW;
                  retry_s = 8'd0;
               end
            end else begin
               state_s = ST_WAIT;
            end
         end
         ST_DRAW: begin
            if (draw_legal_s) begin
               lane_s  = rng_data;
               state_s = ST_ISSUE;
            end else if (retry_r < LAST_TRY_C) begin
               retry_s = retry_r + 8'd1;
            end else begin
               lane_s  = fallback_lane(has_last_r, last_lane_r);
               state_s = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (handshake_s) begin
               last_lane_s = lane_r;
               has_last_s  = 1'b1;
               count_s     = (count_r == 8'hFF) ? count_r : (count_r + 8'd1);
               interval_s  = ramped_s;
               if (enable) begin
                  state_s = ST_WAIT;
                  timer_s = ramped_s;
               end else begin
                  state_s = ST_IDLE;
               end
            end else begin
               state_s = ST_ISSUE;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
      valid_s = (state_s == ST_ISSUE);
   end

   // State and output registers; reset drops any pending request.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state_r     <= ST_IDLE;
         timer_r     <= 8'd0;
         retry_r     <= 8'd0;
         has_last_r  <= 1'b0;
         last_lane_r <= 5'd0;
         valid_r     <= 1'b0;
         lane_r      <= 5'd0;
         count_r     <= 8'd0;
         interval_r  <= INIT_C;
      end else begin
         state_r     <= state_s;
         timer_r     <= timer_s;
         retry_r     <= retry_s;
         has_last_r  <= has_last_s;
         last_lane_r <= last_lane_s;
         valid_r     <= valid_s;
         lane_r      <= lane_s;
         count_r     <= count_s;
         interval_r  <= interval_s;
      end
   end

   assign spawn_valid  = valid_r;
   assign spawn_lane   = lane_r;
   assign spawn_count  = count_r;
   assign cur_interval = interval_r;

endmodule

// File: tb/tb_spawn_sched.sv
// Directed bench for spawn_sched: a vector table for the basic flow plus hand-written
// sequences for retry, fallback, backpressure, mid-ISSUE reset and the difficulty ramp.
module tb_spawn_sched;

   logic       clk;
   logic       rst_n;
   logic       enable;
   logic       frame_tick;
   logic [4:0] rng_data;
   logic       spawn_ready;
   logic       spawn_valid;
   logic [4:0] spawn_lane;
   logic [7:0] spawn_count;
   logic [7:0] cur_interval;

   int n_vec;
   int n_err;

   typedef struct {
      logic       rst;
      logic       en;
      logic       tick;
      logic [4:0] rng;
      logic       rdy;
      int         cycles;
      logic       ev;
      int         el;
      int         ec;
      int         ei;
   } vec_t;

   vec_t tbl[12];

   spawn_sched dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .enable       (enable),
      .frame_tick   (frame_tick),
      .rng_data     (rng_data),
      .spawn_ready  (spawn_ready),
      .spawn_valid  (spawn_valid),
      .spawn_lane   (spawn_lane),
      .spawn_count  (spawn_count),
      .cur_interval (cur_interval)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   // Negative expected lane/count/interval means "don't care".
   task automatic chk(input string name, input logic ev, input int el, input int ec, input int ei);
      logic bad;
      bad = 1'b0;
      n_vec++;
      if (spawn_valid !== ev) begin
         $display("FAIL %s: spawn_valid=%0b expected %0b", name, spawn_valid, ev);
         bad = 1'b1;
      end
      if (el >= 0 && spawn_lane !== 5'(el)) begin
         $display("FAIL %s: spawn_lane=%0d expected %0d", name, spawn_lane, el);
         bad = 1'b1;
      end
      if (ec >= 0 && spawn_count !== 8'(ec)) begin
         $display("FAIL %s: spawn_count=%0d expected %0d", name, spawn_count, ec);
         bad = 1'b1;
      end
      if (ei >= 0 && cur_interval !== 8'(ei)) begin
         $display("FAIL %s: cur_interval=%0d expected %0d", name, cur_interval, ei);
         bad = 1'b1;
      end
      if (bad) n_err++;
   endtask

   initial begin
      int cnt;
      int ivl;
      int k;
      n_vec       = 0;
      n_err       = 0;
      rst_n       = 1'b1;
      enable      = 1'b0;
      frame_tick  = 1'b0;
      rng_data    = 5'd0;
      spawn_ready = 1'b0;

      //          rst   en    tick  rng    rdy   cyc  ev    lane cnt int
      tbl[0]  = '{1'b1, 1'b0, 1'b0, 5'd0,  1'b0, 2,  1'b0, 0,   0,  30};
      tbl[1]  = '{1'b0, 1'b1, 1'b0, 5'd7,  1'b0, 1,  1'b0, 0,   0,  30};
      tbl[2]  = '{1'b0, 1'b1, 1'b1, 5'd7,  1'b0, 29, 1'b0, 0,   0,  30};
      tbl[3]  = '{1'b0, 1'b1, 1'b1, 5'd7,  1'b0, 1,  1'b0, 0,   0,  30};
      tbl[4]  = '{1'b0, 1'b1, 1'b0, 5'd7,  1'b0, 1,  1'b1, 7,   0,  30};
      tbl[5]  = '{1'b0, 1'b1, 1'b0, 5'd7,  1'b1, 1,  1'b0, 7,   1,  29};
      tbl[6]  = '{1'b0, 1'b1, 1'b1, 5'd7,  1'b0, 29, 1'b0, 7,   1,  29};
      tbl[7]  = '{1'b0, 1'b1, 1'b0, 5'd7,  1'b0, 1,  1'b0, 7,   1,  29};
      tbl[8]  = '{1'b0, 1'b1, 1'b0, 5'd25, 1'b0, 1,  1'b0, 7,   1,  29};
      tbl[9]  = '{1'b0, 1'b1, 1'b0, 5'd3,  1'b0, 1,  1'b1, 3,   1,  29};
      tbl[10] = '{1'b0, 1'b0, 1'b0, 5'd3,  1'b1, 1,  1'b0, 3,   2,  28};
      tbl[11] = '{1'b0, 1'b0, 1'b1, 5'd3,  1'b1, 5,  1'b0, 3,   2,  28};

      @(negedge clk);
      for (int i = 0; i < 12; i++) begin
         rst_n       = tbl[i].rst;
         enable      = tbl[i].en;
         frame_tick  = tbl[i].tick;
         rng_data    = tbl[i].rng;
         spawn_ready = tbl[i].rdy;
         cyc(tbl[i].cycles);
         chk($sformatf("vec%0d", i), tbl[i].ev, tbl[i].el, tbl[i].ec, tbl[i].ei);
      end

      // Retry: 31, 25, 20 rejected, 12 accepted on the fourth draw.
      spawn_ready = 1'b0; frame_tick = 1'b0; enable = 1'b1;
      cyc(1);
      frame_tick = 1'b1;
      cyc(28);
      chk("retry_enter", 1'b0, -1, 2, 28);
      frame_tick = 1'b0;
      rng_data = 5'd31; cyc(1); chk("retry_d1", 1'b0, -1, 2, 28);
      rng_data = 5'd25; cyc(1); chk("retry_d2", 1'b0, -1, 2, 28);
      rng_data = 5'd20; cyc(1); chk("retry_d3", 1'b0, -1, 2, 28);
      rng_data = 5'd12; cyc(1); chk("retry_d4", 1'b1, 12, 2, 28);
      spawn_ready = 1'b1; cyc(1); chk("retry_hs", 1'b0, 12, 3, 27);
      spawn_ready = 1'b0;

      // Spawn lane 19, then keep drawing 19 so the fallback wraps to 0.
      frame_tick = 1'b1; cyc(27);
      frame_tick = 1'b0; rng_data = 5'd19; cyc(1);
      chk("lane19", 1'b1, 19, 3, 27);
      spawn_ready = 1'b1; cyc(1); chk("lane19_hs", 1'b0, 19, 4, 26);
      spawn_ready = 1'b0;
      frame_tick = 1'b1; cyc(26);
      frame_tick = 1'b0;
      cyc(3); chk("fallback_wait", 1'b0, 19, 4, 26);
      cyc(1); chk("fallback_wrap", 1'b1, 0, 4, 26);

      // Backpressure: request held while everything else toggles.
      for (int i = 0; i < 50; i++) begin
         rng_data   = 5'(i);
         frame_tick = i[0];
         enable     = i[1];
         cyc(1);
         chk("backpressure", 1'b1, 0, 4, 26);
      end
      enable = 1'b1; frame_tick = 1'b0; spawn_ready = 1'b1;
      cyc(1); chk("bp_accept", 1'b0, 0, 5, 25);
      spawn_ready = 1'b0;
      frame_tick = 1'b1; cyc(24);
      frame_tick = 1'b0; rng_data = 5'd5;
      cyc(2); chk("interval25_early", 1'b0, 0, 5, 25);
      frame_tick = 1'b1; cyc(1); chk("interval25_draw", 1'b0, 0, 5, 25);
      frame_tick = 1'b0; cyc(1); chk("interval25_issue", 1'b1, 5, 5, 25);

      // Asynchronous reset while a request is pending.
      rst_n = 1'b1;
      #1;
      chk("reset_async", 1'b0, 0, 0, 30);
      cyc(1);
      rst_n = 1'b0; enable = 1'b1; rng_data = 5'd31;
      cyc(1);
      frame_tick = 1'b1; cyc(29);
      frame_tick = 1'b0; cyc(2); chk("reset_no_early", 1'b0, 0, 0, 30);
      frame_tick = 1'b1; cyc(1); chk("reset_draw", 1'b0, 0, 0, 30);
      frame_tick = 1'b0;
      cyc(3); chk("nolast_wait", 1'b0, 0, 0, 30);
      cyc(1); chk("nolast_fallback", 1'b1, 0, 0, 30);

      // Ramp: 300 accepted spawns with ticks every clock.
      spawn_ready = 1'b1; frame_tick = 1'b1; enable = 1'b1;
      cnt = 0;
      ivl = 30;
      for (int s = 0; s < 300; s++) begin
         k = 0;
         while (!spawn_valid && k < 200) begin
            rng_data = 5'($urandom_range(0, 19));
            cyc(1);
            k++;
         end
         if (!spawn_valid) begin
            n_vec++;
            n_err++;
            $display("FAIL ramp_timeout: spawn %0d not seen, spawn_valid=%0b expected 1", s, spawn_valid);
            break;
         end
         cyc(1);
         cnt = (cnt < 255) ? cnt + 1 : 255;
         ivl = (ivl > 8) ? ivl - 1 : 8;
         chk($sformatf("ramp%0d", s), 1'b0, -1, cnt, ivl);
      end
      chk("ramp_final", 1'b0, -1, 255, 8);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/spawn_sched.md
Name: spawn_sched

Overview:
- Consumes the 5-bit pseudo-random word from the game's RNG stage and converts it into timed obstacle/enemy spawn requests for the game-object manager.
- Counts frame ticks between spawns and draws a legal lane from the random word, retrying on out-of-range or repeated values.
- Presents each spawn on a valid/ready handshake.
- Shortens the spawn interval after every accepted spawn, so difficulty ramps up over time.

Parameters:
- NUM_LANES, 20, number of legal lanes; legal values 0..NUM_LANES-1; range 1..32.
- INTERVAL_INIT, 30, frame ticks between spawns after reset; must be >= MIN_INTERVAL.
- MIN_INTERVAL, 8, floor for the interval; must be >= 1.
- STEP, 1, interval decrement per accepted spawn.
- MAX_RETRY, 4, number of draw cycles before fallback; must be >= 1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous reset, active-high (asserted = 1)
- enable  in  1  game running; 0 pauses scheduling
- frame_tick  in  1  one-clk pulse per video frame
- rng_data  in  5  random word; changes every clk
- spawn_ready  in  1  object manager accepts the request
- spawn_valid  out  1  request pending
- spawn_lane  out  5  lane of the pending request
- spawn_count  out  8  accepted spawns, saturating at 255
- cur_interval  out  8  current interval in frame ticks

Behaviour:
- Reset (async, rst_n=1):
  - state=IDLE; spawn_valid=0, spawn_lane=0, spawn_count=0.
  - cur_interval=INTERVAL_INIT; timer=0, retry=0, has_last=0, last_lane=0.
- IDLE:
  - spawn_valid=0.
  - enable=1 → WAIT, timer<=cur_interval.
- WAIT:
  - enable=0 → IDLE; timer is discarded and reloaded on re-entry.
  - Otherwise, on frame_tick: if timer>1, timer<=timer-1; if timer==1 → DRAW, retry<=0.
  - Result: exactly cur_interval frame_ticks separate entry from DRAW.
- DRAW (one draw per clk, samples rng_data):
  - A draw is legal iff rng_data<NUM_LANES AND NOT(has_last AND rng_data==last_lane).
  - Legal draw → spawn_lane<=rng_data, → ISSUE.
  - Illegal draw with retry<MAX_RETRY-1 → retry<=retry+1, stay in DRAW.
  - Illegal draw with retry==MAX_RETRY-1 → fallback: spawn_lane<=(has_last ? (last_lane+1) mod NUM_LANES : 0), → ISSUE.
  - enable is ignored in DRAW.
  - frame_tick is ignored in DRAW and ISSUE (not banked).
- ISSUE:
  - spawn_valid=1.
  - spawn_lane is held stable until the handshake completes.
  - enable is ignored: a pending request is never withdrawn.
- Handshake (spawn_valid & spawn_ready on a clk edge):
  - last_lane<=spawn_lane; has_last<=1.
  - spawn_count<=min(spawn_count+1, 255).
  - cur_interval<=max(cur_interval-STEP, MIN_INTERVAL); compute without underflow (compare before subtracting).
  - Next state: WAIT with timer<=the new interval if enable=1, else IDLE.
  - spawn_valid deasserts the cycle after the handshake.
- Latency:
  - Legal first draw: spawn_valid rises 2 clk edges after the frame_tick that expires the timer (edge 1 enters DRAW, edge 2 accepts the draw).
  - Worst case: MAX_RETRY+1 edges.
- spawn_ready while spawn_valid=0: no effect.
- Outputs are registered; no combinational path from rng_data or spawn_ready to any output.
- Reset mid-operation (any state, including ISSUE with valid high): immediate return to reset values; the pending spawn is lost.

Test Plan:
- Reset mid-ISSUE:
  - Stimulus: assert rst_n with spawn_valid=1, spawn_count=3.
  - Response: same-cycle (async) spawn_valid=0, spawn_count=0, cur_interval=30; no spawn until 30 more ticks after enable.
- Basic spawn:
  - Stimulus: enable=1, rng_data fixed at 7, spawn_ready=1, frame_tick every 10 clks.
  - Response: spawn_valid rises exactly 2 edges after the 30th tick with lane=7; spawn_count=1, cur_interval=29 after the handshake.
- Rejection/retry:
  - Stimulus: rng_data sequence 31,25,20,12 in DRAW.
  - Response: lane=12 accepted on the 4th draw (retry reached 3 without fallback).
- Fallback and no-repeat:
  - Stimulus: last_lane=19, rng_data stuck at 19 for 4 draws.
  - Response: lane=0 via (19+1) mod 20.
  - Stimulus: has_last=0, rng_data stuck at 31.
  - Response: lane=0.
- Backpressure:
  - Stimulus: hold spawn_ready=0 for 50 clks while toggling rng_data, frame_tick and enable.
  - Response: spawn_valid stays 1, spawn_lane unchanged, timer not reloaded; accepted on the first ready cycle.
- Ramp and saturation:
  - Stimulus: 300 back-to-back accepted spawns.
  - Response: cur_interval decreases 30→8 then holds at 8; spawn_count holds at 255.
